mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped countdown timer that acts as a responder on the nRisc data bus, alongside `data_memory`. It decodes the processor's `memWrite`/`memRead`/`endereco`/`escreveDado` strobes for a four-register window and returns read data on `leDado`. It runs a prescaled down-counter with one-shot and auto-reload modes, a sticky expiry flag and an interrupt line. The top level muxes `leDado` between `data_memory` and this block using `hit`.

## Interface
- `BASE`, 8'hF0: base address of the register window. Must be 4-aligned.
- `PRESCALE`, 4: clock cycles per count tick. Must be ≥1; width is `$clog2(PRESCALE)`, min 1 bit.
- `clock` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `memWrite` in 1: write strobe from the processor.
- `memRead` in 1: read strobe from the processor.
- `endereco` in 8: byte address.
- `escreveDado` in 8: write data.
- `leDado` out 8: read data, combinational.
- `hit` out 1: combinational; high when `endereco[7:2]==BASE[7:2]` and (`memRead` or `memWrite`).
- `irq` out 1: registered interrupt request.

## Operation
- Register map, offset `endereco[1:0]`:
  - 0 `CTRL`, R/W: bit0 `en`, bit1 `auto`, bit2 `irq_en`. Bits 7:3 read 0.
  - 1 `COUNT`: reads the current count; a write loads the count.
  - 2 `RELOAD`, R/W.
  - 3 `STATUS`: bit0 `expired` (sticky). Writing 1 to bit0 clears it; writing 0 has no effect.
- Reads:
  - `leDado` = addressed register when `memRead && hit`, else 8'h00.
  - Reads have no side effects.
- Writes act at the rising edge when `memWrite && hit`. Accesses outside the window are ignored.
- If `memRead` and `memWrite` are both high, the write is performed and `leDado` shows the pre-write value.
- Prescaler `pre` runs only in RUN. It counts 0..PRESCALE-1; a tick occurs on the edge where `pre==PRESCALE-1`, and `pre` wraps to 0.
- State machine:
  - **IDLE**: `en=0`, count frozen, `pre=0`.
    - A CTRL write with bit0=1: `count<=RELOAD`, `pre<=0`, go to RUN.
  - **RUN**: on each tick:
    - If `count!=0`: `count<=count-1`.
    - If `count==0`: `expired<=1`.
      - If `auto`: `count<=RELOAD`, stay in RUN.
      - Otherwise: clear `en`, go to DONE.
    - A CTRL write with bit0=0: go to IDLE immediately. Count is held and `pre` is cleared.
    - A CTRL write with bit0=1 while in RUN restarts: `count<=RELOAD`, `pre<=0`.
  - **DONE**: count holds 0, `en=0`.
    - A CTRL write with bit0=1 behaves as in IDLE.
    - Any other CTRL write moves to IDLE.
- COUNT write in RUN: `count<=escreveDado`, `pre<=0`. In IDLE/DONE it only loads the value.
- RELOAD write never alters the current count.
- Period = (RELOAD+1)×PRESCALE cycles. RELOAD=0 expires on the first tick.
- Simultaneous events:
  - Expiry in the same cycle as a STATUS clear write: `expired` ends at 1 (set wins).
  - Expiry in the same cycle as a COUNT write: the write wins for `count`, and `expired` is still set.
- `irq` is the registered value of `expired & irq_en`. It updates one edge after either input changes.

## Timing
- Reset values:
  - CTRL=0, COUNT=0, RELOAD=0, `expired`=0, `pre`=0, state IDLE.
  - `irq`=0.
  - `leDado`=0 and `hit`=0 while the bus is idle.
- Reset asserted mid-count clears everything immediately, without waiting for a clock edge.
- Read latency: 0 cycles, combinational, valid in the same cycle as `memRead`.
- Write latency: visible on read in the cycle after the edge that performs the write.
- Enable written at edge k:
  - Ticks occur at edges k+PRESCALE·n.
  - `expired` is set at edge k+(RELOAD+1)·PRESCALE.
  - `irq` rises one edge later if `irq_en`.

## Test plan
- **Reset and idle bus:** assert reset with the bus idle.
  - Required: `leDado`=0, `hit`=0, `irq`=0.
  - Then read 0xF0–0xF3: all return 0.
  - Then read 0xEF: `hit`=0.
- **One-shot run:** write RELOAD=3, then CTRL=8'h05 at edge k (PRESCALE=4).
  - Required: COUNT reads 3,2,1,0 across ticks.
  - STATUS=1 at edge k+16, `irq` high at k+17.
  - CTRL reads 8'h04, state DONE.
- **Auto-reload:** RELOAD=1, CTRL=8'h07.
  - Required: `expired` set at k+8.
  - COUNT reloads to 1 and the next expiry occurs at k+16.
  - Writing STATUS=1 between expiries clears `expired`, and `irq` drops one edge later.
- **Set-vs-clear collision:** issue a STATUS=1 write exactly at the expiry edge.
  - Required: STATUS reads 1 afterwards.
- **Disable and restart:** CTRL=0 written mid-count at COUNT=2.
  - Required: COUNT holds 2.
  - Writing COUNT=9 then CTRL=1 reloads from RELOAD, not from 9.
- **Async reset mid-run:** pulse reset between clock edges during RUN.
  - Required: `irq`, COUNT and STATUS are 0 before the next edge.
  - A simultaneous `memRead`+`memWrite` to RELOAD returns the old value that cycle and the new value the next cycle.

Source files
------------

// File: rtl/mmio_timer_if.sv
// Data-bus bundle between the nRisc core (master) and memory-mapped responders (slave).
interface mmio_timer_if;
    logic       memWrite;
    logic       memRead;
    logic [7:0] endereco;
    logic [7:0] escreveDado;
    logic [7:0] leDado;
    logic       hit;

    modport master (output memWrite, memRead, endereco, escreveDado, input leDado, hit);
    modport slave  (input memWrite, memRead, endereco, escreveDado, output leDado, hit);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled countdown timer: CTRL/COUNT/RELOAD/STATUS window,
// one-shot or auto-reload, sticky expiry flag and registered interrupt.
module mmio_timer #(
    parameter logic [7:0] BASE     = 8'hF0,
    parameter int         PRESCALE = 4
) (
    input  logic          clock,
    input  logic          reset,
    mmio_timer_if.slave   bus,
    output logic          irq
);
    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        r_state, w_state_n;
    logic          r_auto, w_auto_n;
    logic          r_irq_en, w_irq_en_n;
    logic          r_expired, w_expired_n;
    logic          r_irq;
    logic [7:0]    r_count, w_count_n;
    logic [7:0]    r_reload, w_reload_n;
    logic [PW-1:0] r_pre, w_pre_n;

    logic       w_hit, w_wr, w_tick, w_set, w_clr;
    logic [1:0] w_off;
    logic [7:0] w_rdata;

    assign w_hit  = (bus.endereco[7:2] == BASE[7:2]) && (bus.memRead || bus.memWrite);
    assign w_wr   = bus.memWrite && w_hit;
    assign w_off  = bus.endereco[1:0];
    assign w_tick = (r_state == S_RUN) && (r_pre == PRE_MAX);

    // The enable bit is not stored: it is exactly "the FSM is in RUN".
    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            2'd0: w_rdata = {5'b0, r_irq_en, r_auto, r_state == S_RUN};
            2'd1: w_rdata = r_count;
            2'd2: w_rdata = r_reload;
            2'd3: w_rdata = {7'b0, r_expired};
            default: w_rdata = 8'h00;
        endcase
    end

    assign bus.hit    = w_hit;
    assign bus.leDado = (bus.memRead && w_hit) ? w_rdata : 8'h00;
    assign irq        = r_irq;

    always_comb begin
        w_state_n  = r_state;
        w_auto_n   = r_auto;
        w_irq_en_n = r_irq_en;
        w_count_n  = r_count;
        w_reload_n = r_reload;
        w_pre_n    = r_pre;
        w_set      = 1'b0;
        w_clr      = 1'b0;

        if (r_state == S_RUN) begin
            if (w_tick) begin
                w_pre_n = '0;
                if (r_count != 8'h00) begin
                    w_count_n = r_count - 8'h01;
                end else begin
                    w_set = 1'b1;
                    if (r_auto) w_count_n = r_reload;
                    else        w_state_n = S_DONE;
                end
            end else begin
                w_pre_n = r_pre + 1'b1;
            end
        end

        // Bus writes come last so they override tick effects on count/state.
        if (w_wr) begin
            case (w_off)
                2'd0: begin
                    w_auto_n   = bus.escreveDado[1];
                    w_irq_en_n = bus.escreveDado[2];
                    w_pre_n    = '0;
                    if (bus.escreveDado[0]) begin
                        w_count_n = r_reload;
                        w_state_n = S_RUN;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
                2'd1: begin
                    w_count_n = bus.escreveDado;
                    w_pre_n   = '0;
                end
                2'd2: w_reload_n = bus.escreveDado;
                2'd3: w_clr      = bus.escreveDado[0];
                default: ;
            endcase
        end

        w_expired_n = (r_expired & ~w_clr) | w_set;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_auto    <= 1'b0;
            r_irq_en  <= 1'b0;
            r_expired <= 1'b0;
            r_irq     <= 1'b0;
            r_count   <= 8'h00;
            r_reload  <= 8'h00;
            r_pre     <= '0;
        end else begin
            r_state   <= w_state_n;
            r_auto    <= w_auto_n;
            r_irq_en  <= w_irq_en_n;
            r_expired <= w_expired_n;
            r_irq     <= r_expired & r_irq_en;
            r_count   <= w_count_n;
            r_reload  <= w_reload_n;
            r_pre     <= w_pre_n;
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: vector table, timed corner sequences and
// randomized bus traffic against a cycle-countdown reference model.
module tb_mmio_timer;
    localparam int P = 4;

    logic clock = 1'b0;
    logic reset;
    logic irq;
    mmio_timer_if bif ();

    mmio_timer #(.BASE(8'hF0), .PRESCALE(P)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif.slave),
        .irq   (irq)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: timer described as "cycles left until next tick".
    bit       m_run, m_auto, m_ien, m_exp, m_irq;
    bit [7:0] m_count, m_reload;
    int       m_left;

    task automatic model_reset();
        m_run = 0; m_auto = 0; m_ien = 0; m_exp = 0; m_irq = 0;
        m_count = 0; m_reload = 0; m_left = P;
    endtask

    function automatic bit m_hit(logic wr, logic rd, logic [7:0] a);
        return (a >= 8'hF0) && (a <= 8'hF3) && (wr || rd);
    endfunction

    function automatic logic [7:0] m_read(logic wr, logic rd, logic [7:0] a);
        if (!(rd && m_hit(wr, rd, a))) return 8'h00;
        case (a - 8'hF0)
            8'd0:    return {5'b0, m_ien, m_auto, m_run};
            8'd1:    return m_count;
            8'd2:    return m_reload;
            default: return {7'b0, m_exp};
        endcase
    endfunction

    task automatic model_step(logic wr, logic rd, logic [7:0] a, logic [7:0] d);
        bit set, nirq;
        set  = 0;
        nirq = m_exp & m_ien;
        if (m_run) begin
            if (m_left == 1) begin
                m_left = P;
                if (m_count > 0) m_count = m_count - 1;
                else begin
                    set = 1;
                    if (m_auto) m_count = m_reload;
                    else        m_run = 0;
                end
            end else begin
                m_left = m_left - 1;
            end
        end
        if (wr && m_hit(wr, rd, a)) begin
            case (a - 8'hF0)
                8'd0: begin
                    m_auto = d[1]; m_ien = d[2]; m_run = d[0]; m_left = P;
                    if (d[0]) m_count = m_reload;
                end
                8'd1: begin m_count = d; m_left = P; end
                8'd2: m_reload = d;
                default: if (d[0]) m_exp = 0;
            endcase
        end
        if (set) m_exp = 1;
        m_irq = nirq;
    endtask

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive just after a rising edge, sample on the falling edge,
    // compare with the model, then let the model follow the next rising edge.
    task automatic bus(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] q, output logic h, output logic ir);
        bif.memWrite = wr; bif.memRead = rd; bif.endereco = a; bif.escreveDado = d;
        @(negedge clock);
        q = bif.leDado; h = bif.hit; ir = irq;
        chk("model_leDado", q, m_read(wr, rd, a));
        chk("model_hit", {7'b0, h}, {7'b0, m_hit(wr, rd, a)});
        chk("model_irq", {7'b0, ir}, {7'b0, m_irq});
        @(posedge clock);
        model_step(wr, rd, a, d);
        #1;
        bif.memWrite = 1'b0; bif.memRead = 1'b0;
    endtask

    typedef struct {
        logic       wr, rd;
        logic [7:0] a, d;
        logic       exp_hit;
        logic [7:0] exp_q;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [7:0] q, a, d;
        logic       h, ir, wr, rd;

        bif.memWrite = 0; bif.memRead = 0; bif.endereco = 8'h00; bif.escreveDado = 8'h00;
        reset = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #2;
        chk("rst_leDado", bif.leDado, 8'h00);
        chk("rst_hit", {7'b0, bif.hit}, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        @(posedge clock); #1;
        reset = 1'b0;

        tbl[0]  = '{0, 1, 8'hF0, 8'h00, 1, 8'h00};
        tbl[1]  = '{0, 1, 8'hF1, 8'h00, 1, 8'h00};
        tbl[2]  = '{0, 1, 8'hF2, 8'h00, 1, 8'h00};
        tbl[3]  = '{0, 1, 8'hF3, 8'h00, 1, 8'h00};
        tbl[4]  = '{0, 1, 8'hEF, 8'h00, 0, 8'h00};
        tbl[5]  = '{1, 0, 8'hF2, 8'h5A, 1, 8'h00};
        tbl[6]  = '{0, 1, 8'hF2, 8'h00, 1, 8'h5A};
        tbl[7]  = '{1, 0, 8'hF0, 8'h06, 1, 8'h00};
        tbl[8]  = '{0, 1, 8'hF0, 8'h00, 1, 8'h06};
        tbl[9]  = '{1, 0, 8'hF1, 8'h33, 1, 8'h00};
        tbl[10] = '{0, 1, 8'hF1, 8'h00, 1, 8'h33};
        tbl[11] = '{1, 0, 8'hE2, 8'h11, 0, 8'h00};
        tbl[12] = '{0, 1, 8'hF2, 8'h00, 1, 8'h5A};
        tbl[13] = '{1, 1, 8'hF2, 8'h77, 1, 8'h5A};
        tbl[14] = '{0, 1, 8'hF2, 8'h00, 1, 8'h77};
        tbl[15] = '{1, 0, 8'hF3, 8'h01, 1, 8'h00};
        tbl[16] = '{0, 1, 8'hF3, 8'h00, 1, 8'h00};
        tbl[17] = '{0, 1, 8'hF4, 8'h00, 0, 8'h00};
        tbl[18] = '{0, 0, 8'hF1, 8'h00, 0, 8'h00};
        for (int i = 0; i < 19; i++) begin
            bus(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d, q, h, ir);
            chk($sformatf("tbl%0d_q", i), q, tbl[i].exp_q);
            chk($sformatf("tbl%0d_hit", i), {7'b0, h}, {7'b0, tbl[i].exp_hit});
        end

        // One-shot, RELOAD=3: expiry 16 edges after enable, irq one edge later.
        bus(1, 0, 8'hF2, 8'h03, q, h, ir);
        bus(1, 0, 8'hF0, 8'h05, q, h, ir);
        for (int j = 1; j <= 16; j++) begin
            bus(0, 1, 8'hF1, 8'h00, q, h, ir);
            chk("oneshot_count", q, 8'(3 - (j - 1) / 4));
        end
        bus(0, 1, 8'hF3, 8'h00, q, h, ir);
        chk("oneshot_status", q, 8'h01);
        chk("oneshot_irq_late", {7'b0, ir}, 8'h00);
        bus(0, 1, 8'hF0, 8'h00, q, h, ir);
        chk("oneshot_ctrl", q, 8'h04);
        chk("oneshot_irq", {7'b0, ir}, 8'h01);

        // Auto-reload RELOAD=1, STATUS clears at j=11 and j=18, collision at j=24.
        bus(1, 0, 8'hF3, 8'h01, q, h, ir);
        bus(1, 0, 8'hF2, 8'h01, q, h, ir);
        bus(1, 0, 8'hF0, 8'h07, q, h, ir);
        for (int j = 1; j <= 25; j++) begin
            if (j == 11 || j == 18 || j == 24) bus(1, 0, 8'hF3, 8'h01, q, h, ir);
            else if (j == 10)                  bus(0, 1, 8'hF1, 8'h00, q, h, ir);
            else                               bus(0, 1, 8'hF3, 8'h00, q, h, ir);
            if (j <= 8 || (j >= 12 && j <= 16) || (j >= 19 && j <= 23))
                chk($sformatf("auto_status_j%0d", j), q, 8'h00);
            if (j == 9 || j == 17) chk($sformatf("auto_expired_j%0d", j), q, 8'h01);
            if (j == 10) begin
                chk("auto_reload_count", q, 8'h01);
                chk("auto_irq_set", {7'b0, ir}, 8'h01);
            end
            if (j == 12) chk("auto_irq_hold", {7'b0, ir}, 8'h01);
            if (j == 13) chk("auto_irq_drop", {7'b0, ir}, 8'h00);
            if (j == 25) chk("collision_status", q, 8'h01);
        end

        // Disable at COUNT=2, then restart reloads from RELOAD.
        bus(1, 0, 8'hF0, 8'h00, q, h, ir);
        bus(1, 0, 8'hF3, 8'h01, q, h, ir);
        bus(1, 0, 8'hF2, 8'h05, q, h, ir);
        bus(1, 0, 8'hF0, 8'h01, q, h, ir);
        for (int j = 1; j <= 13; j++) begin
            bus(0, 1, 8'hF1, 8'h00, q, h, ir);
            chk("restart_count", q, 8'(5 - (j - 1) / 4));
        end
        bus(1, 0, 8'hF0, 8'h00, q, h, ir);
        for (int j = 0; j < 3; j++) begin
            bus(0, 1, 8'hF1, 8'h00, q, h, ir);
            chk("disable_hold", q, 8'h02);
        end
        bus(1, 0, 8'hF1, 8'h09, q, h, ir);
        bus(0, 1, 8'hF1, 8'h00, q, h, ir);
        chk("count_load", q, 8'h09);
        bus(1, 0, 8'hF0, 8'h01, q, h, ir);
        bus(0, 1, 8'hF1, 8'h00, q, h, ir);
        chk("restart_from_reload", q, 8'h05);

        // Raise irq, then pulse reset between edges.
        bus(1, 0, 8'hF2, 8'h00, q, h, ir);
        bus(1, 0, 8'hF0, 8'h05, q, h, ir);
        for (int j = 1; j <= 6; j++) bus(0, 1, 8'hF3, 8'h00, q, h, ir);
        chk("pre_reset_irq", {7'b0, ir}, 8'h01);
        bif.memRead = 1'b1; bif.endereco = 8'hF1;
        reset = 1'b1;
        #1;
        chk("async_irq", {7'b0, irq}, 8'h00);
        chk("async_count", bif.leDado, 8'h00);
        bif.endereco = 8'hF3;
        #1;
        chk("async_status", bif.leDado, 8'h00);
        reset = 1'b0;
        bif.memRead = 1'b0;
        model_reset();
        bus(1, 0, 8'hF2, 8'hAA, q, h, ir);
        bus(1, 1, 8'hF2, 8'h55, q, h, ir);
        chk("rdwr_old", q, 8'hAA);
        bus(0, 1, 8'hF2, 8'h00, q, h, ir);
        chk("rdwr_new", q, 8'h55);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            a = ($urandom_range(0, 99) < 85) ? {6'h3C, 2'($urandom_range(0, 3))} : 8'($urandom);
            wr = ($urandom_range(0, 3) == 0);
            rd = 1'($urandom_range(0, 1));
            case (a[1:0])
                2'd1:    d = 8'($urandom_range(0, 10));
                2'd2:    d = 8'($urandom_range(0, 6));
                default: d = 8'($urandom);
            endcase
            bus(wr, rd, a, d, q, h, ir);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
